// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared types, constants and the hex-to-segment glyph table for the
// seven-segment display controller.
//   status_t   : calculator status code (ok / busy / error / overflow)
//   SEG_BLANK  : all segments dark (segments are active-low)
//   SEG_A..DP  : bit positions inside a segment byte {dp,g,f,e,d,c,b,a}
//   hex_to_seg : 4-bit value -> active-low glyph with the dp segment dark
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_BUSY = 2'b01,
        ST_ERR  = 2'b10,
        ST_OVF  = 2'b11
    } status_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Glyphs for 0-9, A, b, C, d, E, F. A zero bit lights the segment.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] value);
        logic [7:0] seg;
        case (value)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational decode of one digit into an active-low segment byte.
//   value_i : hex nibble to show
//   valid_i : 0 blanks the glyph segments
//   dp_i    : 1 lights the decimal point (independent of valid_i)
//   seg_o   : {dp,g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       valid_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o         = valid_i ? hex_to_seg(value_i) : SEG_BLANK;
        seg_o[SEG_DP] = ~dp_i;
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_display_ctrl
// Digit register file plus static and scanned seven-segment output paths.
//   clock, reset : system clock, asynchronous active-low reset
//   wr_en/wr_pos/wr_data : one nibble write per cycle, 0 = rightmost digit;
//                          positions >= NUM_DIGITS are ignored
//   clear        : blanks every digit; beats a simultaneous write
//   status       : 00 ok, 01 busy (dp on top digit), 10 error (blink),
//                  11 overflow (dp on digit 0)
//   scan_mode    : 0 drives seg_out, 1 drives scan_seg/scan_an
//   seg_out      : byte i = digit i, {dp,g,f,e,d,c,b,a}, active-low
//   scan_seg     : segment byte of the currently scanned digit
//   scan_an      : one-hot active-low anode select
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros.
// ---------------------------------------------------------------------------
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_pos,
    input  logic [3:0]                    wr_data,
    input  logic                          clear,
    input  logic [1:0]                    status,
    input  logic                          scan_mode,
    output logic [8*NUM_DIGITS-1:0]       seg_out,
    output logic [7:0]                    scan_seg,
    output logic [NUM_DIGITS-1:0]         scan_an
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    status_t st;
    assign st = status_t'(status);

    logic [3:0]            digit_val [NUM_DIGITS];
    logic [7:0]            digit_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_valid;
    logic [NUM_DIGITS-1:0] digit_on;
    logic [NUM_DIGITS-1:0] digit_dp;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  blink_off;

    logic [8*NUM_DIGITS-1:0] seg_out_q, seg_out_d;
    logic [7:0]              scan_seg_q, scan_seg_d;
    logic [NUM_DIGITS-1:0]   scan_an_q, scan_an_d;
    logic [7:0]              scan_dec_seg;

    // ------------------------------------------------------------------
    // Blink timebase: free-running from reset, phase starts "on".
    // ------------------------------------------------------------------
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic               blink_wrap;

    always_comb begin
        blink_wrap  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_on_d  = blink_wrap ? ~blink_on_q : blink_on_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign blink_off = (st == ST_ERR) && !blink_on_q;

    // ------------------------------------------------------------------
    // Scan timebase: counter keeps running in static mode so switching
    // modes never restarts the walk.
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic              scan_wrap;

    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_wrap) begin
            scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression: walk down from the top digit; zeros seen
    // before the first valid nonzero digit are blanked. Digit 0 is never
    // suppressed so a lone zero stays visible.
    // ------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    logic lz_seen_nz;

    always_comb begin
        lz_blank   = '0;
        lz_seen_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (digit_valid[i] && (digit_val[i] != 4'h0)) begin
                lz_seen_nz = 1'b1;
            end
            lz_blank[i] = !lz_seen_nz;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // ------------------------------------------------------------------
    // Per-digit storage, status shaping and static-path decode.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] val_q;
            logic       valid_q;
            logic       wr_hit;

            // No digit matches an out-of-range position, so such writes vanish.
            assign wr_hit = wr_en && (wr_pos == IDX_W'(gi));

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    val_q   <= 4'h0;
                    valid_q <= 1'b0;
                end else if (clear) begin
                    valid_q <= 1'b0;
                end else if (wr_hit) begin
                    val_q   <= wr_data;
                    valid_q <= 1'b1;
                end
            end

            assign digit_val[gi]   = val_q;
            assign digit_valid[gi] = valid_q;
            assign digit_on[gi]    = valid_q & ~lz_blank[gi] & ~blink_off;
            assign digit_dp[gi]    = ((gi == NUM_DIGITS - 1) && (st == ST_BUSY)) ||
                                     ((gi == 0) && (st == ST_OVF));

            seg7_decode u_decode (
                .value_i (val_q),
                .valid_i (digit_on[gi]),
                .dp_i    (digit_dp[gi]),
                .seg_o   (digit_seg[gi])
            );

            assign seg_out_d[8*gi +: 8] = scan_mode ? SEG_BLANK : digit_seg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scan path: one shared decoder fed from the digit under the index.
    // ------------------------------------------------------------------
    seg7_decode u_scan_decode (
        .value_i (digit_val[scan_idx_q]),
        .valid_i (digit_on[scan_idx_q]),
        .dp_i    (digit_dp[scan_idx_q]),
        .seg_o   (scan_dec_seg)
    );

    assign scan_seg_d = scan_mode ? scan_dec_seg : SEG_BLANK;
    assign scan_an_d  = scan_mode ? ~(NUM_DIGITS'(1) << scan_idx_q) : '1;

    // Segment and anode registers share one edge so no stale glyph shows
    // on a newly selected anode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_out_q  <= '1;
            scan_seg_q <= SEG_BLANK;
            scan_an_q  <= '1;
        end else begin
            seg_out_q  <= seg_out_d;
            scan_seg_q <= scan_seg_d;
            scan_an_q  <= scan_an_d;
        end
    end

    assign seg_out  = seg_out_q;
    assign scan_seg = scan_seg_q;
    assign scan_an  = scan_an_q;

endmodule
